// File: rtl/lpf1s_comp_if.sv
// Sample stream, coefficient write port and status flag of the LPF1s compensator.
interface lpf1s_comp_if #(
  parameter int DW = 16,
  parameter int CW = 18
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 coef_wr;
  logic [1:0]           coef_sel;
  logic signed [CW-1:0] coef_data;
  logic                 clr;
  logic                 sat;

  // Producer/controller side (sample source, sink and coefficient host).
  modport master (
    output in_valid, in_data, out_ready, coef_wr, coef_sel, coef_data, clr,
    input  in_ready, out_valid, out_data, sat
  );

  // Compensator side.
  modport slave (
    input  in_valid, in_data, out_ready, coef_wr, coef_sel, coef_data, clr,
    output in_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/lpf1s_comp.sv
// First-order pole/zero compensator: y[n] = round(C0*x[n] + C1*x[n-1] - C2*y[n-1]) >> FRAC,
// saturated to DW bits. One sample every four clocks: accept, multiply, accumulate, output.
module lpf1s_comp #(
  parameter int DW      = 16,
  parameter int CW      = 18,
  parameter int FRAC    = 16,
  parameter int C0_INIT = 65536,
  parameter int C1_INIT = 0,
  parameter int C2_INIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  lpf1s_comp_if.slave   bus
);

  localparam int PW = CW + DW;
  localparam int AW = PW + 2;

  localparam logic signed [AW-1:0] RND  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_OUT} state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] x1_q, x1_d;
  logic signed [DW-1:0] y1_q, y1_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 sat_q, sat_d;

  logic signed [CW-1:0] c0s_q, c0s_d, c1s_q, c1s_d, c2s_q, c2s_d;
  logic signed [CW-1:0] c0a_q, c0a_d, c1a_q, c1a_d, c2a_q, c2a_d;

  logic signed [PW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;

  logic                 accept;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] y_rnd;
  logic signed [DW-1:0] y_sat;
  logic                 y_clip;

  // Full-precision signed product; both operands are sign-extended first.
  function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c,
                                               input logic signed [DW-1:0] d);
    return PW'(c) * PW'(d);
  endfunction

  // Round half toward +inf, then drop the fractional bits.
  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] a);
    return (a + RND) >>> FRAC;
  endfunction

  // Clamp to the representable output range.
  function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] v);
    if (v > YMAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < YMIN) return {1'b1, {(DW-1){1'b0}}};
    else               return v[DW-1:0];
  endfunction

  // True when saturate() would have to clamp.
  function automatic logic clips(input logic signed [AW-1:0] v);
    return (v > YMAX) || (v < YMIN);
  endfunction

  // CLR takes priority over a pending sample while idle.
  assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.clr;

  // State register; control and the filter state visible through the ports reset together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      c0s_q      <= CW'(C0_INIT);
      c1s_q      <= CW'(C1_INIT);
      c2s_q      <= CW'(C2_INIT);
      c0a_q      <= CW'(C0_INIT);
      c1a_q      <= CW'(C1_INIT);
      c2a_q      <= CW'(C2_INIT);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      c0s_q      <= c0s_d;
      c1s_q      <= c1s_d;
      c2s_q      <= c2s_d;
      c0a_q      <= c0a_d;
      c1a_q      <= c1a_d;
      c2a_q      <= c2a_d;
    end
  end

  // In-flight sample and products; always written before use, so no reset needed.
  always_ff @(posedge clk) begin
    x_q  <= x_d;
    p0_q <= p0_d;
    p1_q <= p1_d;
    p2_q <= p2_d;
  end

  // Next-state logic: accept -> multiply -> accumulate -> hold until downstream takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_MUL;
      S_MUL:   state_d = S_ACC;
      S_ACC:   state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture, multiply, accumulate/round/saturate, filter state and coefficients.
  always_comb begin
    x_d        = x_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    c0s_d      = c0s_q;
    c1s_d      = c1s_q;
    c2s_d      = c2s_q;
    c0a_d      = c0a_q;
    c1a_d      = c1a_q;
    c2a_d      = c2a_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;

    acc_sum = AW'(p0_q) + AW'(p1_q) - AW'(p2_q);
    y_rnd   = round_shift(acc_sum);
    y_sat   = saturate(y_rnd);
    y_clip  = clips(y_rnd);

    // Shadow writes land in any state; reserved select is dropped.
    if (bus.coef_wr) begin
      unique case (bus.coef_sel)
        2'd0:    c0s_d = bus.coef_data;
        2'd1:    c1s_d = bus.coef_data;
        2'd2:    c2s_d = bus.coef_data;
        default: ;
      endcase
    end

    // Stage p0: capture the sample and freeze the coefficient set for its whole flight.
    if (accept) begin
      x_d   = bus.in_data;
      c0a_d = c0s_q;
      c1a_d = c1s_q;
      c2a_d = c2s_q;
    end

    // Stage p1: register the three products.
    if (state_q == S_MUL) begin
      p0_d = mul(c0a_q, x_q);
      p1_d = mul(c1a_q, x1_q);
      p2_d = mul(c2a_q, y1_q);
    end

    // Stage p2: publish the result and advance the recursion with the clamped value.
    if (state_q == S_ACC) begin
      out_data_d = y_sat;
      y1_d       = y_sat;
      x1_d       = x_q;
      sat_d      = sat_q | y_clip;
    end

    if ((state_q == S_IDLE) && bus.clr) begin
      x1_d  = '0;
      y1_d  = '0;
      sat_d = 1'b0;
    end
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_OUT);
    bus.out_data  = out_data_q;
    bus.sat       = sat_q;
  end

endmodule
